boreal_packet_rx: RTL and testbench

BOREAL_PACKET_RX -- requirements
Module: boreal_packet_rx

---
 rtl/boreal_packet_rx.sv | 202 ++++++++++++++++++++
 tb/tb_boreal_packet_rx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/boreal_packet_rx.sv
// boreal_packet_rx
//   UART (8N1, LSB first) receiver feeding a cursor packet parser.
//   Packet: 0xA5, dx, dy, buttons [, chk = dx ^ dy ^ buttons].
//
// Optional feature macro: BOREAL_RX_CHECKSUM_EN
//   defined   -> 5-byte packets, checksum verified, chk_err can pulse
//   undefined -> 4-byte packets, chk_err tied low
//
// Ports
//   clk        system clock, everything on the rising edge
//   rst        synchronous active-high reset
//   uart_rx    asynchronous serial line, idles high
//   pkt_valid  one-cycle pulse when an accepted packet is latched
//   dx, dy     signed deltas of the last accepted packet
//   left_btn   buttons bit 0 of the last accepted packet
//   right_btn  buttons bit 1 of the last accepted packet
//   frame_err  one-cycle pulse on a stop-bit error
//   chk_err    one-cycle pulse on a checksum mismatch
//
// Bit FSM
//   state   | meaning
//   B_IDLE  | waiting for a falling edge, inter-byte gap timer running
//   B_START | counting to the start-bit centre to reject glitches
//   B_DATA  | sampling 8 data bits at bit centres
//   B_STOP  | sampling the stop bit, then handing the byte to the parser
//
// Packet parser
//   state     | meaning
//   P_HUNT    | discarding bytes until 0xA5
//   P_GOT_HDR | header seen, next byte is dx
//   P_GOT_DX  | dx captured, next byte is dy
//   P_GOT_DY  | dy captured, next byte is buttons
//   P_CHK     | buttons captured, next byte is checksum (checksum build only)

module boreal_packet_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       pkt_valid,
  output logic [7:0] dx,
  output logic [7:0] dy,
  output logic       left_btn,
  output logic       right_btn,
  output logic       frame_err,
  output logic       chk_err
);

  // One width for both down-counters so the gap timer can hold the full timeout.
  localparam int CNT_W = $clog2(CLKS_PER_BIT * TIMEOUT_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(CLKS_PER_BIT * TIMEOUT_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;

  typedef enum logic [2:0] {
    P_HUNT, P_GOT_HDR, P_GOT_DX, P_GOT_DY
`ifdef BOREAL_RX_CHECKSUM_EN
    , P_CHK
`endif
  } pstate_t;

  logic             rx_meta, rx_sync, rx_prev;
  bstate_t          bstate;
  pstate_t          pstate;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic [7:0]       sh_dx, sh_dy;
`ifdef BOREAL_RX_CHECKSUM_EN
  logic [7:0]       sh_btn;
`endif

  // Synchroniser resets to the idle level so reset release looks like an idle line.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bstate    <= B_IDLE;
      pstate    <= P_HUNT;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      sh_dx     <= '0;
      sh_dy     <= '0;
`ifdef BOREAL_RX_CHECKSUM_EN
      sh_btn    <= '0;
`endif
      dx        <= '0;
      dy        <= '0;
      left_btn  <= 1'b0;
      right_btn <= 1'b0;
      pkt_valid <= 1'b0;
      frame_err <= 1'b0;
      chk_err   <= 1'b0;
    end else begin
      pkt_valid <= 1'b0;
      frame_err <= 1'b0;
      chk_err   <= 1'b0;

      case (bstate)
        B_IDLE: begin
          // Gap timer only runs between bytes; expiry abandons a partial packet.
          if (gap_cnt != '0)
            gap_cnt <= gap_cnt - CNT_ONE;
          else if (pstate != P_HUNT)
            pstate <= P_HUNT;
          if (rx_prev && !rx_sync) begin
            bstate  <= B_START;
            bit_cnt <= HALF_LAST;
            bit_idx <= '0;
          end
        end

        B_START: begin
          if (bit_cnt != '0)
            bit_cnt <= bit_cnt - CNT_ONE;
          else if (!rx_sync) begin
            bstate  <= B_DATA;
            bit_cnt <= BIT_LAST;
          end else
            bstate  <= B_IDLE;
        end

        B_DATA: begin
          if (bit_cnt != '0)
            bit_cnt <= bit_cnt - CNT_ONE;
          else begin
            shreg   <= {rx_sync, shreg[7:1]};
            bit_cnt <= BIT_LAST;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7)
              bstate <= B_STOP;
          end
        end

        B_STOP: begin
          if (bit_cnt != '0)
            bit_cnt <= bit_cnt - CNT_ONE;
          else begin
            // Back to IDLE at the stop-bit centre so the next start edge is not missed.
            bstate <= B_IDLE;
            if (!rx_sync) begin
              frame_err <= 1'b1;
              pstate    <= P_HUNT;
            end else begin
              gap_cnt <= GAP_LOAD;
              case (pstate)
                P_HUNT:    if (shreg == 8'hA5) pstate <= P_GOT_HDR;
                P_GOT_HDR: begin sh_dx <= shreg; pstate <= P_GOT_DX; end
                P_GOT_DX:  begin sh_dy <= shreg; pstate <= P_GOT_DY; end
`ifdef BOREAL_RX_CHECKSUM_EN
                P_GOT_DY:  begin sh_btn <= shreg; pstate <= P_CHK; end
                P_CHK: begin
                  if (shreg == (sh_dx ^ sh_dy ^ sh_btn)) begin
                    dx        <= sh_dx;
                    dy        <= sh_dy;
                    left_btn  <= sh_btn[0];
                    right_btn <= sh_btn[1];
                    pkt_valid <= 1'b1;
                  end else
                    chk_err   <= 1'b1;
                  pstate <= P_HUNT;
                end
`else
                P_GOT_DY: begin
                  dx        <= sh_dx;
                  dy        <= sh_dy;
                  left_btn  <= shreg[0];
                  right_btn <= shreg[1];
                  pkt_valid <= 1'b1;
                  pstate    <= P_HUNT;
                end
`endif
                default: pstate <= P_HUNT;
              endcase
            end
          end
        end

        default: bstate <= B_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boreal_packet_rx.sv
// Testbench for boreal_packet_rx (CLKS_PER_BIT=16, TIMEOUT_BITS=20).
// Serial frames are generated bit by bit; a byte-level packet model predicts
// pulse counts and output values.
module tb_boreal_packet_rx;
  localparam int CPB = 16;
  localparam int TOB = 20;
`ifdef BOREAL_RX_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  localparam int PKT_LEN = CHK_EN ? 5 : 4;

  logic       clk, rst, uart_rx;
  logic       pkt_valid, frame_err, chk_err, left_btn, right_btn;
  logic [7:0] dx, dy;

  boreal_packet_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .pkt_valid(pkt_valid),
    .dx(dx), .dy(dy), .left_btn(left_btn), .right_btn(right_btn),
    .frame_err(frame_err), .chk_err(chk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Pulse monitor: counts high cycles, so a stretched pulse shows up as extra counts.
  int c_pkt = 0, c_ferr = 0, c_cerr = 0, c_multi = 0;
  always @(negedge clk) begin
    if (pkt_valid) c_pkt++;
    if (frame_err) c_ferr++;
    if (chk_err)   c_cerr++;
    if (int'(pkt_valid) + int'(frame_err) + int'(chk_err) > 1) c_multi++;
  end

  // Reference model at packet level.
  int         m_pkts = 0, m_ferr = 0, m_cerr = 0;
  logic [7:0] m_dx = 8'h00, m_dy = 8'h00;
  logic       m_l = 1'b0, m_r = 1'b0;
  bit         m_active = 1'b0;
  logic [7:0] m_buf[$];

  function automatic void model_byte(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) begin
      m_ferr++;
      m_active = 1'b0;
      m_buf.delete();
      return;
    end
    if (!m_active) begin
      m_active = (b == 8'hA5);
      return;
    end
    m_buf.push_back(b);
    if (m_buf.size() == PKT_LEN - 1) begin
      if (CHK_EN && ((m_buf[0] ^ m_buf[1] ^ m_buf[2]) != m_buf[PKT_LEN-2]))
        m_cerr++;
      else begin
        m_pkts++;
        m_dx = m_buf[0];
        m_dy = m_buf[1];
        m_l  = m_buf[2][0];
        m_r  = m_buf[2][1];
      end
      m_active = 1'b0;
      m_buf.delete();
    end
  endfunction

  function automatic void model_gap(input int n);
    if (n > 200) begin
      m_active = 1'b0;
      m_buf.delete();
    end
  endfunction

  function automatic void model_reset();
    m_active = 1'b0;
    m_buf.delete();
    m_dx = 8'h00; m_dy = 8'h00; m_l = 1'b0; m_r = 1'b0;
  endfunction

  task automatic line_bit(input logic v);
    uart_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(b[i]);
    line_bit(stop_ok);
    if (!stop_ok) line_bit(1'b1);
    model_byte(b, stop_ok);
  endtask

  task automatic send_idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
    model_gap(n);
  endtask

  task automatic test_reset();
    rst = 1'b1; uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (dx !== 8'h00) $display("FAIL reset_dx: got %h want 00", dx); else n_pass++;
    n_checks++; if (dy !== 8'h00) $display("FAIL reset_dy: got %h want 00", dy); else n_pass++;
    n_checks++; if ({left_btn, right_btn} !== 2'b00) $display("FAIL reset_btn: got %b want 00", {left_btn, right_btn}); else n_pass++;
    n_checks++; if ({pkt_valid, frame_err, chk_err} !== 3'b000) $display("FAIL reset_pulses: got %b want 000", {pkt_valid, frame_err, chk_err}); else n_pass++;
    rst = 1'b0;
    send_idle(20);
  endtask

  task automatic test_basic();
    int p0;
    p0 = c_pkt;
    send_byte(8'hA5); send_byte(8'h05); send_byte(8'hFB);
    n_checks++; if (c_pkt - p0 !== 0) $display("FAIL basic_early_pkt: got %0d want 0", c_pkt - p0); else n_pass++;
    send_byte(8'h01);
`ifdef BOREAL_RX_CHECKSUM_EN
    send_byte(8'hFF);
`endif
    n_checks++; if (c_pkt - p0 !== 1) $display("FAIL basic_pkt_count: got %0d want 1", c_pkt - p0); else n_pass++;
    n_checks++; if (dx !== 8'h05) $display("FAIL basic_dx: got %h want 05", dx); else n_pass++;
    n_checks++; if (dy !== 8'hFB) $display("FAIL basic_dy: got %h want fb", dy); else n_pass++;
    n_checks++; if ({left_btn, right_btn} !== 2'b10) $display("FAIL basic_btn: got %b want 10", {left_btn, right_btn}); else n_pass++;
  endtask

  task automatic test_hunt();
    int p0;
    p0 = c_pkt;
    send_byte(8'h33); send_byte(8'h7E); send_byte(8'hA5); send_byte(8'h10); send_byte(8'h20);
    n_checks++; if (dx !== 8'h05) $display("FAIL hunt_shadow_dx: got %h want 05", dx); else n_pass++;
    n_checks++; if (dy !== 8'hFB) $display("FAIL hunt_shadow_dy: got %h want fb", dy); else n_pass++;
    send_byte(8'h02);
`ifdef BOREAL_RX_CHECKSUM_EN
    send_byte(8'h32);
`endif
    n_checks++; if (c_pkt - p0 !== 1) $display("FAIL hunt_pkt_count: got %0d want 1", c_pkt - p0); else n_pass++;
    n_checks++; if (dx !== 8'h10) $display("FAIL hunt_dx: got %h want 10", dx); else n_pass++;
    n_checks++; if (dy !== 8'h20) $display("FAIL hunt_dy: got %h want 20", dy); else n_pass++;
    n_checks++; if ({left_btn, right_btn} !== 2'b01) $display("FAIL hunt_btn: got %b want 01", {left_btn, right_btn}); else n_pass++;
  endtask

  task automatic test_frame_err();
    int p0, f0;
    p0 = c_pkt; f0 = c_ferr;
    send_byte(8'hA5);
    send_byte(8'h55, 1'b0);
    n_checks++; if (c_ferr - f0 !== 1) $display("FAIL ferr_count: got %0d want 1", c_ferr - f0); else n_pass++;
    // If the parser failed to drop back to HUNT these would complete a packet.
    send_byte(8'h20); send_byte(8'h30); send_byte(8'h01); send_byte(8'h11);
    n_checks++; if (c_pkt - p0 !== 0) $display("FAIL ferr_hunt_pkt: got %0d want 0", c_pkt - p0); else n_pass++;
    n_checks++; if (dx !== 8'h10) $display("FAIL ferr_dx_hold: got %h want 10", dx); else n_pass++;
    n_checks++; if (dy !== 8'h20) $display("FAIL ferr_dy_hold: got %h want 20", dy); else n_pass++;
    // Short low glitch must be rejected silently.
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    send_idle(3 * CPB);
    send_byte(8'hA5); send_byte(8'h7F); send_byte(8'h80); send_byte(8'h03);
`ifdef BOREAL_RX_CHECKSUM_EN
    send_byte(8'hFC);
`endif
    n_checks++; if (c_ferr - f0 !== 1) $display("FAIL glitch_ferr: got %0d want 1", c_ferr - f0); else n_pass++;
    n_checks++; if (c_pkt - p0 !== 1) $display("FAIL glitch_pkt: got %0d want 1", c_pkt - p0); else n_pass++;
    n_checks++; if ({dx, dy} !== 16'h7F80) $display("FAIL glitch_dxdy: got %h want 7f80", {dx, dy}); else n_pass++;
  endtask

  task automatic test_checksum();
    int p0, k0;
    p0 = c_pkt; k0 = c_cerr;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
`ifdef BOREAL_RX_CHECKSUM_EN
    n_checks++; if (c_cerr - k0 !== 1) $display("FAIL chk_err_count: got %0d want 1", c_cerr - k0); else n_pass++;
    n_checks++; if (c_pkt - p0 !== 0) $display("FAIL chk_pkt_count: got %0d want 0", c_pkt - p0); else n_pass++;
    n_checks++; if ({dx, dy} !== 16'h7F80) $display("FAIL chk_dxdy_hold: got %h want 7f80", {dx, dy}); else n_pass++;
`else
    n_checks++; if (c_cerr - k0 !== 0) $display("FAIL chk_err_count: got %0d want 0", c_cerr - k0); else n_pass++;
    n_checks++; if (c_pkt - p0 !== 1) $display("FAIL chk_pkt_count: got %0d want 1", c_pkt - p0); else n_pass++;
    n_checks++; if ({dx, dy} !== 16'h0102) $display("FAIL chk_dxdy: got %h want 0102", {dx, dy}); else n_pass++;
`endif
  endtask

  task automatic test_timeout();
    int p0;
    p0 = c_pkt;
    send_byte(8'hA5); send_byte(8'h01);
    send_idle(400);
    send_byte(8'h02); send_byte(8'h00);
`ifdef BOREAL_RX_CHECKSUM_EN
    send_byte(8'h03);
`endif
    n_checks++; if (c_pkt - p0 !== 0) $display("FAIL timeout_pkt: got %0d want 0", c_pkt - p0); else n_pass++;
    n_checks++; if ({dx, dy} !== {m_dx, m_dy}) $display("FAIL timeout_hold: got %h want %h", {dx, dy}, {m_dx, m_dy}); else n_pass++;
    send_byte(8'hA5); send_byte(8'hF0); send_byte(8'h0F); send_byte(8'h00);
`ifdef BOREAL_RX_CHECKSUM_EN
    send_byte(8'hFF);
`endif
    n_checks++; if (c_pkt - p0 !== 1) $display("FAIL timeout_next_pkt: got %0d want 1", c_pkt - p0); else n_pass++;
    n_checks++; if ({dx, dy} !== 16'hF00F) $display("FAIL timeout_next_dxdy: got %h want f00f", {dx, dy}); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int p0;
    send_byte(8'hA5); send_byte(8'h01);
    // dy byte 0xFF: start bit, then the line stays high through the reset pulse.
    line_bit(1'b0);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks++; if ({dx, dy} !== 16'h0000) $display("FAIL rstmid_dxdy: got %h want 0000", {dx, dy}); else n_pass++;
    n_checks++; if ({left_btn, right_btn, pkt_valid, frame_err, chk_err} !== 5'b0) $display("FAIL rstmid_flags: got %b want 00000", {left_btn, right_btn, pkt_valid, frame_err, chk_err}); else n_pass++;
    send_idle(400);
    p0 = c_pkt;
    send_byte(8'hA5); send_byte(8'h22); send_byte(8'h33); send_byte(8'h02);
`ifdef BOREAL_RX_CHECKSUM_EN
    send_byte(8'h13);
`endif
    n_checks++; if (c_pkt - p0 !== 1) $display("FAIL rstmid_pkt: got %0d want 1", c_pkt - p0); else n_pass++;
    n_checks++; if ({dx, dy, left_btn, right_btn} !== {16'h2233, 2'b01}) $display("FAIL rstmid_out: got %h %b want 2233 01", {dx, dy}, {left_btn, right_btn}); else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] rdx, rdy, rbt, rchk;
    int kind;
    for (int it = 0; it < 25; it++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 4) begin
        rdx = 8'($urandom); rdy = 8'($urandom); rbt = 8'($urandom);
        send_byte(8'hA5); send_byte(rdx); send_byte(rdy); send_byte(rbt);
`ifdef BOREAL_RX_CHECKSUM_EN
        rchk = rdx ^ rdy ^ rbt;
        if ($urandom_range(0, 3) == 0) rchk = rchk ^ 8'h01;
        send_byte(rchk);
`endif
      end else if (kind <= 6) begin
        send_byte(8'($urandom));
      end else if (kind == 7) begin
        send_byte(8'($urandom), 1'b0);
      end else if (kind == 8) begin
        send_byte(8'hA5);
        send_byte(8'($urandom));
        send_idle(400 + $urandom_range(0, 50));
      end else begin
        send_idle($urandom_range(0, 40));
      end
      n_checks++; if (c_pkt !== m_pkts) $display("FAIL rand_pkt it%0d: got %0d want %0d", it, c_pkt, m_pkts); else n_pass++;
      n_checks++; if ({c_ferr, c_cerr} !== {m_ferr, m_cerr}) $display("FAIL rand_errs it%0d: got %0d/%0d want %0d/%0d", it, c_ferr, c_cerr, m_ferr, m_cerr); else n_pass++;
      n_checks++; if ({dx, dy, left_btn, right_btn} !== {m_dx, m_dy, m_l, m_r}) $display("FAIL rand_out it%0d: got %h want %h", it, {dx, dy, left_btn, right_btn}, {m_dx, m_dy, m_l, m_r}); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    uart_rx = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_hunt();
    test_frame_err();
    test_checksum();
    test_timeout();
    test_reset_mid();
    test_random();
    n_checks++; if (c_multi !== 0) $display("FAIL pulse_overlap: got %0d want 0", c_multi); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
